hb_center_tap_path: RTL and testbench

- Multi-channel, valid-qualified centre-tap path for the interpolation half-band filters.
- Each channel's input sample is multiplied by a runtime signed coefficient, saturated to the output width, and delayed by a runtime-selectable number of samples.
- It aligns the centre tap with the polyphase arm for any half-band order.
- Sits in the Tx interpolation chain between the preceding stage and the half-band output adder; all channels share one handshake.

---
 rtl/hb_pkg.sv | 32 +++
 rtl/hb_sat_mult.sv | 34 +++
 rtl/hb_center_tap_path.sv | 162 ++++++++++++++++
 tb/tb_hb_center_tap_path.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hb_pkg.sv
// Shared defaults, fill-state encoding and the saturation helper for the
// half-band centre-tap path.
package hb_pkg;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_IN_W      = 15;
    localparam int DEF_COEF_W    = 10;
    localparam int DEF_OUT_W     = 23;
    localparam int DEF_MAX_DEPTH = 8;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fill_state_e;

    // Clamp a sign-extended value into the signed range of a width-bit word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                               input int unsigned       width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            sat = hi;
        end else if (value < lo) begin
            sat = lo;
        end else begin
            sat = value;
        end
    endfunction

endpackage

// File: rtl/hb_sat_mult.sv
// Combinational signed sample x coefficient product, saturated to the
// output width, with a flag raised whenever clamping occurred.
module hb_sat_mult
    import hb_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic signed [IN_W-1:0]   sample_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [OUT_W-1:0]  prod_o,
    output logic                     sat_o
);

    localparam int PROD_W = IN_W + COEF_W;

    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] prod_full;
    logic signed [63:0]       prod_wide;
    logic signed [63:0]       prod_clamped;

    // Both operands widened to the full product width so the multiply is exact.
    assign sample_ext   = {{COEF_W{sample_i[IN_W-1]}}, sample_i};
    assign coef_ext     = {{IN_W{coef_i[COEF_W-1]}}, coef_i};
    assign prod_full    = sample_ext * coef_ext;
    assign prod_wide    = {{(64-PROD_W){prod_full[PROD_W-1]}}, prod_full};
    assign prod_clamped = sat(prod_wide, OUT_W);

    assign prod_o = prod_clamped[OUT_W-1:0];
    assign sat_o  = (prod_clamped != prod_wide);

endmodule

// File: rtl/hb_center_tap_path.sv
// Multi-channel centre-tap path: per-channel gain with saturation, followed by
// a runtime-selectable sample delay that is primed before outputs are released.
module hb_center_tap_path
    import hb_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int IN_W      = DEF_IN_W,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int MAX_DEPTH = DEF_MAX_DEPTH,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [NUM_CH*IN_W-1:0]   in_data,
    input  logic [COEF_W-1:0]        coef,
    input  logic [DEPTH_W-1:0]       depth_sel,
    input  logic                     ovf_clr,
    output logic                     out_valid,
    output logic [NUM_CH*OUT_W-1:0]  out_data,
    output logic                     ovf,
    output logic                     busy_fill
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);

    logic signed [IN_W-1:0]  sample      [NUM_CH];
    logic signed [OUT_W-1:0] prod_sat    [NUM_CH];
    logic signed [OUT_W-1:0] tap_sel     [NUM_CH];
    logic [NUM_CH-1:0]       ch_sat;

    logic signed [OUT_W-1:0] line_q      [NUM_CH][MAX_DEPTH];
    logic signed [OUT_W-1:0] out_data_q  [NUM_CH];
    logic signed [OUT_W-1:0] out_data_d  [NUM_CH];

    fill_state_e             state_q, state_d;
    logic [DEPTH_W-1:0]      depth_q, depth_d;
    logic [DEPTH_W-1:0]      fill_cnt_q, fill_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic                    ovf_q, ovf_d;

    logic [DEPTH_W-1:0]      depth_req;
    logic                    depth_chg;
    logic                    primed;
    logic                    emit;
    logic                    any_sat;

    // ---------------------------------------------------------------------
    // Per-channel datapath: gain, delay line and output register
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign sample[gi] = in_data[gi*IN_W +: IN_W];

        hb_sat_mult #(
            .IN_W   (IN_W),
            .COEF_W (COEF_W),
            .OUT_W  (OUT_W)
        ) u_sat_mult (
            .sample_i (sample[gi]),
            .coef_i   (coef),
            .prod_o   (prod_sat[gi]),
            .sat_o    (ch_sat[gi])
        );

        // Tap k of the line holds the product accepted k+1 samples ago.
        always_comb begin
            tap_sel[gi] = line_q[gi][0];
            for (int k = 0; k < MAX_DEPTH; k++) begin
                if (depth_q == DEPTH_W'(k + 1)) begin
                    tap_sel[gi] = line_q[gi][k];
                end
            end
        end

        always_comb begin
            out_data_d[gi] = out_data_q[gi];
            if (in_valid) begin
                out_data_d[gi] = (depth_q == '0) ? prod_sat[gi] : tap_sel[gi];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < MAX_DEPTH; k++) begin
                    line_q[gi][k] <= '0;
                end
                out_data_q[gi] <= '0;
            end else begin
                if (in_valid) begin
                    line_q[gi][0] <= prod_sat[gi];
                    for (int k = 1; k < MAX_DEPTH; k++) begin
                        line_q[gi][k] <= line_q[gi][k-1];
                    end
                end
                out_data_q[gi] <= out_data_d[gi];
            end
        end

        assign out_data[gi*OUT_W +: OUT_W] = out_data_q[gi];
    end

    // ---------------------------------------------------------------------
    // Depth control, fill state machine and sticky overflow
    // ---------------------------------------------------------------------
    assign depth_req = (depth_sel > DEPTH_MAX) ? DEPTH_MAX : depth_sel;
    assign depth_chg = (depth_req != depth_q);
    assign any_sat   = |ch_sat;

    // A sample may leave once at least depth_q samples precede it in this
    // priming epoch; a depth change starts a new epoch and never emits.
    assign primed = (state_q == RUN) || (fill_cnt_q >= depth_q);
    assign emit   = in_valid && !depth_chg && primed;

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = emit;
        ovf_d       = ovf_q;

        if (depth_chg) begin
            depth_d    = depth_req;
            state_d    = FILL;
            fill_cnt_d = in_valid ? DEPTH_W'(1) : '0;
        end else if (in_valid) begin
            if (fill_cnt_q < DEPTH_MAX) begin
                fill_cnt_d = fill_cnt_q + DEPTH_W'(1);
            end
            if (primed) begin
                state_d = RUN;
            end
        end

        if (in_valid && any_sat) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            depth_q     <= '0;
            fill_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign busy_fill = (state_q == FILL);

endmodule

// File: tb/tb_hb_center_tap_path.sv
// Randomised scoreboard bench for hb_center_tap_path against a sample-history model.
module tb_hb_center_tap_path;

    localparam int NUM_CH = 2;
    localparam int IN_W   = 15;
    localparam int COEF_W = 10;
    localparam int OUT_W  = 23;
    localparam int MAXD   = 8;
    localparam int DW     = 4;
    localparam longint SAT_HI = 4194303;
    localparam longint SAT_LO = -4194304;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic [NUM_CH*IN_W-1:0]   in_data = '0;
    logic [COEF_W-1:0]        coef = 10'd256;
    logic [DW-1:0]            depth_sel = '0;
    logic                     ovf_clr = 1'b0;
    logic                     out_valid;
    logic [NUM_CH*OUT_W-1:0]  out_data;
    logic                     ovf;
    logic                     busy_fill;

    hb_center_tap_path dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .coef      (coef),
        .depth_sel (depth_sel),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ovf       (ovf),
        .busy_fill (busy_fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint d0;
        longint d1;
    } pair_t;

    int    checks   = 0;
    int    failures = 0;
    pair_t exp_q[$];

    // Reference model state: every accepted product since reset, plus the
    // active depth and how many samples have arrived since it took effect.
    pair_t  hist[$];
    int     m_depth = 0;
    int     m_cnt   = 0;
    bit     m_run   = 0;
    bit     m_ovf   = 0;
    bit     m_known = 0;
    pair_t  m_last;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint ch(input int c);
        logic signed [OUT_W-1:0] t;
        t = out_data[c*OUT_W +: OUT_W];
        return longint'(t);
    endfunction

    function automatic longint satf(input longint p);
        if (p > SAT_HI) return SAT_HI;
        if (p < SAT_LO) return SAT_LO;
        return p;
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        m_depth = 0;
        m_cnt   = 0;
        m_run   = 0;
        m_ovf   = 0;
        m_known = 0;
    endtask

    // Drive one clock of stimulus, update the model, then check the cycle.
    task automatic step(input bit v, input int x0, input int x1, input int cf,
                        input int ds, input bit clr);
        int     dn;
        bit     chg;
        bit     emit;
        bit     anysat;
        longint r0, r1, cs;
        pair_t  p, e;
        logic [COEF_W-1:0]       cbits;
        logic signed [COEF_W-1:0] cs_l;

        cbits     = cf[COEF_W-1:0];
        cs_l      = cbits;
        cs        = longint'(cs_l);
        in_valid  = v;
        in_data   = {x1[IN_W-1:0], x0[IN_W-1:0]};
        coef      = cbits;
        depth_sel = ds[DW-1:0];
        ovf_clr   = clr;

        dn     = (ds > MAXD) ? MAXD : ds;
        chg    = (dn != m_depth);
        emit   = 0;
        anysat = 0;
        if (chg) begin
            m_depth = dn;
            m_cnt   = 0;
            m_run   = 0;
        end
        if (v) begin
            r0 = longint'(x0) * cs;
            r1 = longint'(x1) * cs;
            p.d0 = satf(r0);
            p.d1 = satf(r1);
            anysat = (p.d0 != r0) || (p.d1 != r1);
            if (!chg && m_cnt >= m_depth) begin
                emit  = 1;
                m_run = 1;
                e = (m_depth == 0) ? p : hist[hist.size() - m_depth];
                exp_q.push_back(e);
                m_last = e;
            end
            m_known = emit;
            hist.push_back(p);
            if (hist.size() > 16) void'(hist.pop_front());
            m_cnt++;
        end
        if (v && anysat) m_ovf = 1;
        else if (clr) m_ovf = 0;

        @(posedge clk);
        #1;
        chk("out_valid", out_valid, emit);
        chk("ovf", ovf, m_ovf);
        chk("busy_fill", busy_fill, !m_run);
        if (!v && m_known) begin
            chk("hold_ch0", ch(0), m_last.d0);
            chk("hold_ch1", ch(1), m_last.d1);
        end
        $display("cyc v=%0b x0=%0d x1=%0d coef=%0d dsel=%0d -> out_valid=%0b ch0=%0d ch1=%0d ovf=%0b busy=%0b",
                 v, x0, x1, cs, ds, out_valid, ch(0), ch(1), ovf, busy_fill);
    endtask

    function automatic int rnd_x();
        return int'($urandom_range(0, 32767)) - 16384;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    always @(negedge clk) begin
        pair_t e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual_ch0=%0d required=none @%0t", ch(0), $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_ch0", ch(0), e.d0);
                chk("sb_ch1", ch(1), e.d1);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy_fill, 1);
        rst = 1'b0;
        model_reset();

        // Depth 5 ramp, gain 256.
        for (int i = 1; i <= 14; i++) step(1, i, rnd_x(), 256, 5, 0);

        // Depth 0 extremes.
        step(0, 0, 0, 256, 0, 0);
        step(1, -16384, 16383, 256, 0, 0);
        step(0, 0, 0, 256, 0, 0);

        // Saturation and sticky overflow, set wins over clear.
        step(1, 16383, -100, 511, 0, 0);
        step(0, 0, 0, 511, 0, 0);
        step(1, 5, 6, 511, 0, 0);
        step(1, 16383, 3, 511, 0, 1);
        step(0, 0, 0, 511, 0, 1);
        step(1, -16384, 1, 511, 0, 0);
        step(0, 0, 0, 256, 0, 1);

        // Depth 3, every other cycle, unit gain.
        for (int i = 1; i <= 5; i++) begin
            step(1, 10 * i, rnd_x(), 1, 3, 0);
            step(0, 0, 0, 1, 3, 0);
        end

        // Depth 4 in RUN, then switch to 2 mid-stream.
        for (int i = 0; i < 10; i++) step(1, rnd_x(), rnd_x(), 256, 4, 0);
        for (int i = 0; i < 8; i++)  step(1, rnd_x(), rnd_x(), 256, 2, 0);

        // Depth 5 stream, then a one-cycle asynchronous reset mid-stream.
        for (int i = 0; i < 9; i++) step(1, rnd_x(), rnd_x(), 256, 5, 0);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_busy", busy_fill, 1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step(1, rnd_x(), rnd_x(), 256, 5, 0);

        // Out-of-range depth request clamps to the maximum.
        for (int i = 0; i < 14; i++) step(1, rnd_x(), rnd_x(), 256, 9, 0);

        // Random traffic: depth hops, gaps, random gains and clears.
        begin
            int ds = 3;
            for (int i = 0; i < 300; i++) begin
                int cf;
                if ($urandom_range(0, 15) == 0) ds = int'($urandom_range(0, 15));
                cf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : 256;
                step($urandom_range(0, 9) < 7, rnd_x(), rnd_x(), cf, ds,
                     $urandom_range(0, 7) == 0);
            end
        end

        step(0, 0, 0, 256, 0, 0);
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
